// File: rtl/fret_event_arbiter.sv
// Edge-detects debounced fret/strum buttons into per-lane pending slots and drains them
// round-robin through one valid/ready port. Optional macro FRET_OVERRUN_CNT_EN adds ovr_count.
module fret_event_arbiter #(
  parameter int LANES = 5,
  parameter int TS_W  = 16,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANES-1:0]  btn_state,
  input  logic              tick,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [LANE_W-1:0] ev_lane,
  output logic              ev_press,
  output logic [TS_W-1:0]   ev_ts,
  output logic [LANES-1:0]  pending,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef FRET_OVERRUN_CNT_EN
  ,
  output logic [7:0]        ovr_count
`endif
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state, state_nxt;
  logic [LANES-1:0]    btn_prev;
  logic [LANES-1:0]    edge_vec;
  logic [TS_W-1:0]     ts;
  logic [LANE_W-1:0]   rr_ptr;
  logic                slot_press [LANES];
  logic [TS_W-1:0]     slot_ts    [LANES];
  logic                gnt_found;
  logic [LANE_W-1:0]   gnt_lane;
  logic                do_grant;
  logic [LANES-1:0]    pending_nxt;
  logic [LANES-1:0]    ovr_vec;

  // Cyclic lane addition; base < LANES and k <= LANES so one fold is enough.
  function automatic logic [LANE_W-1:0] lane_add(input logic [LANE_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= LANES) s = s - LANES;
    return LANE_W'(s);
  endfunction

  function automatic logic [3:0] count_ones(input logic [LANES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {5'd0, n};
    return (s > 9'd255) ? 8'hFF : s[7:0];
  endfunction

  assign edge_vec = btn_state ^ btn_prev;

  // Round-robin pick over the registered pending flags (this cycle's edges are not visible).
  always_comb begin
    gnt_found = 1'b0;
    gnt_lane  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (!gnt_found && pending[lane_add(rr_ptr, k)]) begin
        gnt_found = 1'b1;
        gnt_lane  = lane_add(rr_ptr, k);
      end
    end
  end

  assign do_grant = gnt_found && ((state == IDLE) || ((state == OFFER) && ev_ready));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found) state_nxt = OFFER;
      OFFER:   if (ev_ready && !gnt_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A lane whose slot is moving to the output this cycle can take a new edge without overrun.
  always_comb begin
    pending_nxt = pending;
    ovr_vec     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (edge_vec[i]) begin
        pending_nxt[i] = 1'b1;
        ovr_vec[i]     = pending[i] && !(do_grant && (gnt_lane == LANE_W'(i)));
      end else if (do_grant && (gnt_lane == LANE_W'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (edge_vec[i]) begin
        slot_press[i] <= btn_state[i];
        slot_ts[i]    <= ts;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      btn_prev <= '0;
      ts       <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
      ev_valid <= 1'b0;
      ev_lane  <= '0;
      ev_press <= 1'b0;
      ev_ts    <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn_prev <= btn_state;
      pending  <= pending_nxt;
      ev_valid <= (state_nxt == OFFER);
      if (tick) ts <= ts + 1'b1;
      if (do_grant) begin
        ev_lane  <= gnt_lane;
        ev_press <= slot_press[gnt_lane];
        ev_ts    <= slot_ts[gnt_lane];
        rr_ptr   <= lane_add(gnt_lane, 1);
      end
      if (|ovr_vec)     overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

`ifdef FRET_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovr_count <= 8'd0;
    else if (ovr_clr) ovr_count <= sat_add8(8'd0, count_ones(ovr_vec));
    else              ovr_count <= sat_add8(ovr_count, count_ones(ovr_vec));
  end
`endif

endmodule

// File: tb/tb_fret_event_arbiter.sv
// Directed bench for fret_event_arbiter; define FRET_OVERRUN_CNT_EN to also exercise ovr_count.
module tb_fret_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] btn_state;
  logic       tick;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_lane;
  logic       ev_press;
  logic [15:0] ev_ts;
  logic [4:0] pending;
  logic       overrun;
  logic       ovr_clr;
`ifdef FRET_OVERRUN_CNT_EN
  logic [7:0] ovr_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fret_event_arbiter #(.LANES(5), .TS_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_state (btn_state),
    .tick      (tick),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_lane   (ev_lane),
    .ev_press  (ev_press),
    .ev_ts     (ev_ts),
    .pending   (pending),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
`ifdef FRET_OVERRUN_CNT_EN
    ,
    .ovr_count (ovr_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    btn_state = '0;
    tick      = 1'b0;
    ev_ready  = 1'b0;
    ovr_clr   = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; btn_state = '0; tick = 1'b0; ev_ready = 1'b0; ovr_clr = 1'b0;
    repeat (3) step();
    chk("rst_valid",   32'(ev_valid), 32'd0);
    chk("rst_pending", 32'(pending),  32'd0);
    chk("rst_overrun", 32'(overrun),  32'd0);
    chk("rst_lane",    32'(ev_lane),  32'd0);
    chk("rst_press",   32'(ev_press), 32'd0);
    chk("rst_ts",      32'(ev_ts),    32'd0);
    rst_n = 1'b1;

    // single lane 2 press at ts=7
    tick = 1'b1;
    repeat (7) step();
    tick = 1'b0;
    ev_ready = 1'b1;
    btn_state = 5'b00100;
    step();
    chk("t1_pend",      32'(pending),  32'h04);
    chk("t1_valid_lat", 32'(ev_valid), 32'd0);
    step();
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_lane",  32'(ev_lane),  32'd2);
    chk("t1_press", 32'(ev_press), 32'd1);
    chk("t1_ts",    32'(ev_ts),    32'd7);
    chk("t1_pend0", 32'(pending),  32'd0);
    step();
    chk("t1_idle",  32'(ev_valid), 32'd0);

    // lanes 0,1,3 together, back-to-back
    reset_dut();
    ev_ready = 1'b1;
    btn_state = 5'b01011;
    step();
    chk("t2_pend", 32'(pending), 32'h0B);
    step();
    chk("t2_v0", 32'(ev_valid), 32'd1);
    chk("t2_l0", 32'(ev_lane),  32'd0);
    step();
    chk("t2_v1", 32'(ev_valid), 32'd1);
    chk("t2_l1", 32'(ev_lane),  32'd1);
    step();
    chk("t2_v3", 32'(ev_valid), 32'd1);
    chk("t2_l3", 32'(ev_lane),  32'd3);
    chk("t2_pend0", 32'(pending), 32'd0);
    step();
    chk("t2_idle", 32'(ev_valid), 32'd0);
    chk("t2_rr",   32'(dut.rr_ptr), 32'd4);

    // backpressure on lane 4, overwrites while the slot is occupied
    reset_dut();
    btn_state = 5'b10000;
    step();
    step();
    chk("t3_valid", 32'(ev_valid), 32'd1);
    chk("t3_lane",  32'(ev_lane),  32'd4);
    btn_state = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t3_hold_valid", 32'(ev_valid), 32'd1);
      chk("t3_hold_lane",  32'(ev_lane),  32'd4);
      chk("t3_hold_press", 32'(ev_press), 32'd1);
      chk("t3_hold_ts",    32'(ev_ts),    32'd0);
      if (i == 0) begin
        chk("t3_no_ovr_first", 32'(overrun), 32'd0);
        btn_state = 5'b10000;
      end else if (i == 1) begin
        btn_state = 5'b00000;
      end
    end
    chk("t3_overrun", 32'(overrun), 32'd1);
    chk("t3_pend",    32'(pending), 32'h10);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("t3_ovr_clr", 32'(overrun), 32'd0);
    ev_ready = 1'b1;
    step();
    chk("t3_v2",     32'(ev_valid), 32'd1);
    chk("t3_l2",     32'(ev_lane),  32'd4);
    chk("t3_release", 32'(ev_press), 32'd0);
    step();
    chk("t3_idle", 32'(ev_valid), 32'd0);

    // starvation: lane 0 toggling, lane 1 pressed once
    reset_dut();
    ev_ready = 1'b1;
    btn_state = 5'b00011;
    step();
    btn_state = 5'b00010;
    step();
    chk("t4_g1_lane", 32'(ev_lane), 32'd0);
    chk("t4_g1_ovr",  32'(overrun), 32'd0);
    btn_state = 5'b00011;
    step();
    chk("t4_g2_lane",  32'(ev_lane),  32'd1);
    chk("t4_g2_press", 32'(ev_press), 32'd1);
    chk("t4_ovr",      32'(overrun),  32'd1);

    // timestamp wrap, reset mid-offer, button held through reset
    reset_dut();
    tick = 1'b1;
    repeat (65535) step();
    chk("t5_ts_max", 32'(dut.ts), 32'hFFFF);
    step();
    tick = 1'b0;
    chk("t5_ts_wrap", 32'(dut.ts), 32'd0);
    btn_state = 5'b01000;
    step();
    step();
    chk("t5_valid", 32'(ev_valid), 32'd1);
    chk("t5_lane",  32'(ev_lane),  32'd3);
    chk("t5_ts",    32'(ev_ts),    32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(ev_valid), 32'd0);
    chk("t5_rst_pend",  32'(pending),  32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("t5_held_pend", 32'(pending), 32'h08);
    step();
    chk("t5_held_valid", 32'(ev_valid), 32'd1);
    chk("t5_held_lane",  32'(ev_lane),  32'd3);
    chk("t5_held_press", 32'(ev_press), 32'd1);

`ifdef FRET_OVERRUN_CNT_EN
    // overwrite counter saturation and clear
    reset_dut();
    chk("t6_rst_cnt", 32'(ovr_count), 32'd0);
    btn_state = 5'b00001;
    step();
    for (int i = 0; i < 310; i++) begin
      btn_state[0] = ~btn_state[0];
      step();
    end
    chk("t6_sat", 32'(ovr_count), 32'd255);
    ovr_clr = 1'b1;
    step();
    chk("t6_clr", 32'(ovr_count), 32'd0);
    btn_state[0] = ~btn_state[0];
    step();
    ovr_clr = 1'b0;
    chk("t6_set_wins", 32'(ovr_count), 32'd1);
    chk("t6_ovr_set",  32'(overrun),   32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
